dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_if.sv | 24 ++
 rtl/dmem_resp.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: request/response bundle between the CPU memory stage and dmem_resp.
//   req, we, addr[31:0], wdata[31:0], dmtype[2:0]  : request, driven by the master (CPU)
//   rdata[31:0], ack, err, busy                   : response, driven by the slave (dmem_resp)
interface dmem_resp_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dmtype;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, dmtype,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, dmtype,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: word-organised data memory with byte/half/word loads and stores,
// alignment/type fault detection and a one-cycle ack pulse per accepted access.
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset (memory contents are kept)
//   bus  : dmem_resp_if.slave (req/we/addr/wdata/dmtype in; rdata/ack/err/busy out)
// Optional feature: define DMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait cycles
// before every response; otherwise latency is one cycle and busy is tied low.
module dmem_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  dmem_resp_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

`ifdef DMEM_WAIT_STATE_EN
  typedef enum logic [1:0] {IDLE, RESP, WAIT} state_t;
`else
  typedef enum logic {IDLE, RESP} state_t;
`endif

  state_t state_q, state_d;

  logic [3:0][7:0] mem [DEPTH];

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_dmtype;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;

  logic          do_access;
  logic          fault;
  logic          mem_we;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic [31:0]   rd_word;

  logic          ack_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          unused_addr_bits;

  // Misaligned word/half or reserved type codes fault without touching memory.
  function automatic logic is_fault(input logic [2:0] t, input logic [1:0] off);
    logic f;
    f = 1'b0;
    case (t)
      3'd0:       f = (off != 2'd0);
      3'd1, 3'd2: f = off[0];
      3'd3, 3'd4: f = 1'b0;
      default:    f = 1'b1;
    endcase
    return f;
  endfunction

  // Pick the addressed lane(s) and sign/zero extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] t);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (t)
      3'd0:    r = w;
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = {16'h0000, h};
      3'd3:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'h000000, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

`ifdef DMEM_WAIT_STATE_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_dmtype;
  logic          busy_q;

  // While waiting the access is served from the request captured at accept time.
  always_comb begin
    acc_we     = bus.we;
    acc_addr   = bus.addr;
    acc_wdata  = bus.wdata;
    acc_dmtype = bus.dmtype;
    if (state_q == WAIT) begin
      acc_we     = lat_we;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
      acc_dmtype = lat_dmtype;
    end
  end

  // Request capture register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0000_0000;
      lat_wdata  <= 32'h0000_0000;
      lat_dmtype <= 3'd0;
    end else if (bus.req && (state_q != WAIT)) begin
      lat_we     <= bus.we;
      lat_addr   <= bus.addr;
      lat_wdata  <= bus.wdata;
      lat_dmtype <= bus.dmtype;
    end
  end
`else
  // Without wait states the access completes on the accept edge itself.
  always_comb begin
    acc_we     = bus.we;
    acc_addr   = bus.addr;
    acc_wdata  = bus.wdata;
    acc_dmtype = bus.dmtype;
  end
`endif

  assign acc_idx          = acc_addr[AW+1:2];
  assign acc_off          = acc_addr[1:0];
  assign unused_addr_bits = ^acc_addr[31:AW+2];

  // Next-state logic.
  always_comb begin
    state_d = IDLE;
`ifdef DMEM_WAIT_STATE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (bus.req) begin
`ifdef DMEM_WAIT_STATE_EN
          state_d = WAIT;
          cnt_d   = CW'(WAIT_CYCLES - 1);
`else
          state_d = RESP;
`endif
        end
      end
`ifdef DMEM_WAIT_STATE_EN
      WAIT: begin
        if (cnt_q == CW'(0)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // The access happens on whichever edge enters RESP; reset suppresses it.
  assign do_access = rst && (state_d == RESP);
  assign fault     = is_fault(acc_dmtype, acc_off);
  assign mem_we    = do_access && acc_we && !fault;
  assign rd_word   = mem[acc_idx];

  // Store lane enables and lane-replicated write data.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = acc_wdata;
    case (acc_dmtype)
      3'd0: lane_en = 4'b1111;
      3'd1, 3'd2: begin
        lane_en   = acc_off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{acc_wdata[15:0]}};
      end
      3'd3, 3'd4: begin
        lane_en   = 4'b0001 << acc_off;
        lane_data = {4{acc_wdata[7:0]}};
      end
      default: lane_en = 4'b0000;
    endcase
  end

  // Memory array: byte-lane writes, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[acc_idx][i] <= lane_data[8*i +: 8];
      end
    end
  end

  // State and registered response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      ack_q   <= do_access;
      err_q   <= do_access && fault;
      rdata_q <= (do_access && !acc_we && !fault) ? load_ext(rd_word, acc_off, acc_dmtype)
                                                  : 32'h0000_0000;
    end
  end

`ifdef DMEM_WAIT_STATE_EN
  // Wait counter and busy flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= CW'(0);
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (state_d == WAIT);
    end
  end

  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp. Expected responses are pushed when a
// request is driven and popped when ack is seen. Works with or without DMEM_WAIT_STATE_EN.
module tb_dmem_resp;

  localparam int unsigned DEPTH       = 1024;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_STATE_EN
  localparam int LAT = WAIT_CYCLES + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_resp_if bus();

  dmem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          ack_cyc_q[$];
  logic [31:0] ref_mem [int];
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: independent fault decode, lane merge and extension.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [2:0] t);
    exp_t        e;
    int          idx;
    logic [1:0]  off;
    logic [31:0] word;
    logic [15:0] h;
    logic [7:0]  b;
    idx     = int'((a >> 2) % DEPTH);
    off     = a[1:0];
    e.err   = (t > 3'd4) || (t == 3'd0 && off != 2'd0) || ((t == 3'd1 || t == 3'd2) && off[0]);
    e.rdata = 32'h0;
    if (e.err) return e;
    word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (w) begin
      case (t)
        3'd0:    word = wd;
        3'd1,
        3'd2:    word[16*off[1] +: 16] = wd[15:0];
        default: word[8*off +: 8] = wd[7:0];
      endcase
      ref_mem[idx] = word;
    end else begin
      h = word[16*off[1] +: 16];
      b = word[8*off +: 8];
      case (t)
        3'd0:    e.rdata = word;
        3'd1:    e.rdata = 32'($signed(h));
        3'd2:    e.rdata = 32'(h);
        3'd3:    e.rdata = 32'($signed(b));
        default: e.rdata = 32'(b);
      endcase
    end
    return e;
  endfunction

  // Drive one request when the DUT is not busy; returns after the accept edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] t, input bit fixed = 1'b0,
                       input logic [31:0] fixed_rd = 32'h0, input logic fixed_err = 1'b0);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("busy_timeout", 32'd1, 32'd0);
    bus.req    = 1'b1;
    bus.we     = w;
    bus.addr   = a;
    bus.wdata  = wd;
    bus.dmtype = t;
    e = model(w, a, wd, t);
    if (fixed) begin
      e.err   = fixed_err;
      e.rdata = fixed_rd;
    end
    exp_q.push_back(e);
    @(posedge clk);
    acc_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Response monitor, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.ack === 1'b1) begin
      ack_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("err", 32'(bus.err), 32'(mon_e.err));
        check("rdata", bus.rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_cyc;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = 32'h0;
    bus.wdata  = 32'h0;
    bus.dmtype = 3'd0;
    rst        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b1;

    // Sign/zero-extended byte loads
    issue(1'b1, 32'h10, 32'h8000_00F1, 3'd0, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'd3, 1'b1, 32'hFFFF_FFF1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 3'd4, 1'b1, 32'h0000_00F1, 1'b0);
    idle();
    drain();

    // Half store over a word keeps the other lanes
    issue(1'b1, 32'h20, 32'h1111_1111, 3'd0);
    issue(1'b1, 32'h22, 32'h0000_ABCD, 3'd1);
    issue(1'b0, 32'h20, 32'h0, 3'd0, 1'b1, 32'hABCD_1111, 1'b0);
    idle();
    drain();

    // Faults: misaligned and reserved types, memory left unchanged
    issue(1'b0, 32'h6, 32'h0, 3'd0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h3, 32'h0, 3'd1, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h22, 32'hDEAD_BEEF, 3'd0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h21, 32'hDEAD_BEEF, 3'd2, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h20, 32'hDEAD_BEEF, 3'd5, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 3'd7, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 32'h0, 3'd0, 1'b1, 32'hABCD_1111, 1'b0);
    idle();
    drain();
    check("idle_rdata", bus.rdata, 32'h0);
    check("idle_ack", 32'(bus.ack), 32'd0);

    // Address wrap modulo 4*DEPTH
    issue(1'b1, 32'h1000, 32'h5A5A_5A5A, 3'd0);
    issue(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h5A5A_5A5A, 1'b0);
    idle();
    drain();

    // Store then immediate loads; back-to-back throughput and latency
    ack_cyc_q.delete();
    issue(1'b1, 32'h10, 32'hCAFE_F00D, 3'd0);
    first_cyc = acc_cyc;
    issue(1'b0, 32'h13, 32'h0, 3'd4, 1'b1, 32'h0000_00CA, 1'b0);
    issue(1'b0, 32'h12, 32'h0, 3'd1, 1'b1, 32'hFFFF_CAFE, 1'b0);
    idle();
    drain();
    check("b2b_acks", 32'(ack_cyc_q.size()), 32'd3);
    if (ack_cyc_q.size() == 3) begin
      check("b2b_latency", 32'(ack_cyc_q[0] - first_cyc), 32'(LAT));
`ifndef DMEM_WAIT_STATE_EN
      check("b2b_gap1", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd1);
      check("b2b_gap2", 32'(ack_cyc_q[2] - ack_cyc_q[1]), 32'd1);
`endif
    end

`ifdef DMEM_WAIT_STATE_EN
    // Reset during the second wait cycle aborts the store
    issue(1'b1, 32'h40, 32'h0123_4567, 3'd0);
    idle();
    drain();
    @(negedge clk);
    bus.req    = 1'b1;
    bus.we     = 1'b1;
    bus.addr   = 32'h40;
    bus.wdata  = 32'hDEAD_BEEF;
    bus.dmtype = 3'd0;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    check("wait1_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("wait2_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ack", 32'(bus.ack), 32'd0);
    repeat (WAIT_CYCLES + 2) @(posedge clk);
    issue(1'b0, 32'h40, 32'h0, 3'd0, 1'b1, 32'h0123_4567, 1'b0);
    idle();
    drain();
`endif

    // Reset with req held high: ignored, memory preserved
    @(negedge clk);
    rst        = 1'b0;
    bus.req    = 1'b1;
    bus.we     = 1'b1;
    bus.addr   = 32'h20;
    bus.wdata  = 32'hFFFF_FFFF;
    bus.dmtype = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    check("rst2_ack", 32'(bus.ack), 32'd0);
    rst = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 3'd0, 1'b1, 32'hABCD_1111, 1'b0);
    issue(1'b0, 32'h3000, 32'h0, 3'd0, 1'b1, 32'h5A5A_5A5A, 1'b0);
    idle();
    drain();

    // Random mix over 16 initialised words, with aliased addresses
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(4 * i), $urandom, 3'd0);
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12),
            $urandom, 3'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
